// File: rtl/shiftreg_pkg.sv
// ============================================================================
// Module   : shiftreg_pkg
// Brief    : Shared state encoding and default width for the PISO shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shiftreg_pkg;

    localparam int c_default_width = 4;

    typedef logic [0:0] state_t;

    localparam state_t c_st_idle  = 1'b0;
    localparam state_t c_st_shift = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bit_counter.sv
// ============================================================================
// Module   : bit_counter
// Brief    : Counts consumed bits of a frame; flags the last bit position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_counter
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    localparam int c_cnt_w = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               clear,
    input  logic               inc,
    output logic [c_cnt_w-1:0] count,
    output logic               last
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_last;

    assign w_last = (r_count == c_last);

    // Wrapping at the last position keeps the count inside 0..WIDTH-1
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (clear || (inc && w_last)) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = w_last;

endmodule

`default_nettype wire

// File: rtl/piso_shiftreg.sv
// ============================================================================
// Module   : piso_shiftreg
// Brief    : Parallel-in serial-out shifter with ready/valid load and enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shiftreg
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic             ena,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic               r_done;
    logic [WIDTH-1:0]   w_sr_shifted;
    logic               w_out_bit;
    logic               w_fire;
    logic               w_fin;
    logic               w_hs;
    logic               w_last;
    logic [c_cnt_w-1:0] w_count;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
            assign w_out_bit    = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
            assign w_out_bit    = r_sr[0];
        end
    endgenerate

    assign w_fire = (r_state == c_st_shift) && ena;
    assign w_fin  = w_fire && w_last;

    // Ready in the last-bit cycle lets the next frame follow with no gap
    assign load_ready = !clr && ((r_state == c_st_idle) || w_fin);
    assign w_hs       = load_valid && load_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= c_st_idle;
            r_sr    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_hs) begin
                r_sr    <= data;
                r_state <= c_st_shift;
            end else if (w_fin) begin
                r_sr    <= w_sr_shifted;
                r_state <= c_st_idle;
            end else if (w_fire) begin
                r_sr    <= w_sr_shifted;
            end
        end
    end

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .clr   (clr),
        .clear (w_hs),
        .inc   (w_fire),
        .count (w_count),
        .last  (w_last)
    );

    a_count_range : assert property (@(posedge clk) disable iff (clr) w_count <= c_last);

    assign sout       = (r_state == c_st_shift) && w_out_bit;
    assign sout_valid = (r_state == c_st_shift);
    assign busy       = (r_state == c_st_shift);
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_piso_shiftreg.sv
// ============================================================================
// Module   : tb_piso_shiftreg
// Brief    : Bench for piso_shiftreg (both bit orders) against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_shiftreg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] data = '0;
    logic         ena = 1'b0;

    logic rdy_m, sout_m, sv_m, busy_m, done_m;
    logic rdy_l, sout_l, sv_l, busy_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame model: the word being sent and how many of its bits are consumed
    logic         m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_sent = 0;
    logic         m_done = 1'b0;
    logic         m_hs   = 1'b0;

    logic s_ready, s_sout_m, s_sout_l, s_busy, s_done;

    always #5 clk = ~clk;

    piso_shiftreg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(rdy_m),
        .data(data), .ena(ena), .sout(sout_m), .sout_valid(sv_m),
        .busy(busy_m), .done(done_m)
    );

    piso_shiftreg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(rdy_l),
        .data(data), .ena(ena), .sout(sout_l), .sout_valid(sv_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return !clr && (!m_busy || ((m_sent == W - 1) && ena));
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_word = '0;
        m_sent = 0;
        m_done = 1'b0;
        m_hs   = 1'b0;
    endtask

    task automatic model_step();
        logic rdy, fin;
        if (clr) begin
            model_reset();
        end else begin
            rdy    = model_ready();
            fin    = m_busy && ena && (m_sent == W - 1);
            m_hs   = load_valid && rdy;
            m_done = fin;
            if (m_busy && ena) m_sent++;
            if (fin) m_busy = 1'b0;
            if (m_hs) begin
                m_word = data;
                m_sent = 0;
                m_busy = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        logic e_sm, e_sl;
        #2;
        e_sm = m_busy ? m_word[W - 1 - m_sent] : 1'b0;
        e_sl = m_busy ? m_word[m_sent] : 1'b0;
        chk("load_ready_msb", rdy_m, model_ready());
        chk("load_ready_lsb", rdy_l, model_ready());
        chk("sout_msb", sout_m, e_sm);
        chk("sout_lsb", sout_l, e_sl);
        chk("sout_valid", {sv_m, sv_l}, {2{m_busy}});
        chk("busy", {busy_m, busy_l}, {2{m_busy}});
        chk("done", {done_m, done_l}, {2{m_done}});
    end

    task automatic cyc(input logic lv, input logic [W-1:0] d, input logic en, input logic c);
        @(negedge clk);
        load_valid = lv;
        data       = d;
        ena        = en;
        clr        = c;
        if (c) model_reset();
        #3;
        s_ready  = rdy_m;
        s_sout_m = sout_m;
        s_sout_l = sout_l;
        s_busy   = busy_m;
        s_done   = done_m;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic [7:0] seq_m, seq_l;
        logic [2:0] rseq;
        int         ndone;
        logic       pend, c, en;
        logic [W-1:0] pd;
        logic [6:0] pat;

        // Reset state and first cycle after release
        cyc(0, '0, 0, 1);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_sout", s_sout_m, 1'b0);
        chk("rst_done", s_done, 1'b0);
        cyc(0, '0, 1, 0);
        chk("rel_ready", s_ready, 1'b1);

        // 1011, ena held high, both orders
        cyc(1, 4'b1011, 1, 0);
        seq_m = '0; seq_l = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, 1, 0);
            seq_m = {seq_m[6:0], s_sout_m};
            seq_l = {seq_l[6:0], s_sout_l};
        end
        chk("t1_stream_msb", seq_m[3:0], 4'b1011);
        chk("t1_stream_lsb", seq_l[3:0], 4'b1101);
        cyc(0, '0, 1, 0);
        chk("t1_done", s_done, 1'b1);
        chk("t1_busy", s_busy, 1'b0);

        // Enable gaps: 1100 with ena 1,0,0,1,1,0,1
        cyc(1, 4'b1100, 0, 0);
        pat = 7'b1001101;
        seq_m = '0;
        for (int k = 6; k >= 0; k--) begin
            cyc(0, '0, pat[k], 0);
            seq_m = {seq_m[6:0], s_sout_m};
            if (k == 0) chk("t3_last_ready", s_ready, 1'b1);
            else chk("t3_no_early_done", s_done, 1'b0);
        end
        chk("t3_stream", seq_m[6:0], 7'b1111000);
        cyc(0, '0, 0, 0);
        chk("t3_done", s_done, 1'b1);
        chk("t3_busy", s_busy, 1'b0);

        // Back-to-back frames 1010 then 0110
        cyc(1, 4'b1010, 1, 0);
        seq_m = '0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(k == 3, 4'b0110, 1, 0);
            seq_m = {seq_m[6:0], s_sout_m};
            if (k == 3) chk("t4_ready_last", s_ready, 1'b1);
            if (k == 4) chk("t4_busy_gapless", s_busy, 1'b1);
            if (s_done) ndone++;
        end
        cyc(0, '0, 1, 0);
        if (s_done) ndone++;
        chk("t4_stream", seq_m, 8'b10100110);
        chk("t4_done_count", ndone, 2);
        chk("t4_end_busy", s_busy, 1'b0);

        // Held load request during a frame
        cyc(1, 4'b1011, 1, 0);
        rseq = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 4'b1111, 1, 0);
            if (k < 3) rseq = {rseq[1:0], s_ready};
            else chk("t5_ready_last", s_ready, 1'b1);
        end
        chk("t5_ready_blocked", rseq, 3'b000);
        seq_m = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, 1, 0);
            seq_m = {seq_m[6:0], s_sout_m};
        end
        chk("t5_stream", seq_m[3:0], 4'b1111);
        cyc(0, '0, 1, 0);
        chk("t5_done", s_done, 1'b1);

        // Abort mid-frame
        cyc(1, 4'b1011, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 1);
        chk("t6_sout", s_sout_m, 1'b0);
        chk("t6_busy", s_busy, 1'b0);
        chk("t6_ready_in_clr", s_ready, 1'b0);
        chk("t6_done_in_clr", s_done, 1'b0);
        cyc(0, '0, 1, 0);
        chk("t6_ready_release", s_ready, 1'b1);
        chk("t6_no_done", s_done, 1'b0);
        cyc(0, '0, 1, 0);
        chk("t6_no_done_late", s_done, 1'b0);

        // Clear coinciding with a handshake wins
        cyc(1, 4'b1111, 1, 1);
        cyc(0, '0, 0, 0);
        chk("t7_not_captured", s_busy, 1'b0);

        // Randomized traffic; upstream holds a word until it is accepted
        pend = 1'b0;
        pd   = '0;
        for (int i = 0; i < 2500; i++) begin
            c  = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 70);
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pd   = W'($urandom);
            end
            cyc(pend, pd, en, c);
            if (m_hs) pend = 1'b0;
        end
        cyc(0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_shiftreg.md
PISO_SHIFTREG -- requirements
Module: piso_shiftreg

Interface
REQ-001 Parameter WIDTH, default 4, sets the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit data[WIDTH-1] first; 0 = transmit data[0] first.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 load_valid  input  1  upstream presents a parallel word on data.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 data  input  WIDTH  parallel word, captured when load_valid && load_ready.
REQ-008 ena  input  1  shift enable; the current bit is consumed on a cycle with ena=1.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a frame bit.
REQ-011 busy  output  1  a frame is in progress (state SHIFT).
REQ-012 done  output  1  one-cycle pulse after the last bit of a frame is consumed.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT.
REQ-014 In IDLE: load_ready=1, sout=0, sout_valid=0, busy=0, and ena SHALL be ignored.
REQ-015 On a handshake in IDLE, the block SHALL capture data into the shift register, clear the bit counter, and enter SHIFT on the same edge.
REQ-016 In SHIFT: sout_valid=1, busy=1, and sout SHALL equal the shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); the first bit is therefore visible in the cycle after capture.
REQ-017 In SHIFT with ena=1, the register SHALL shift one position toward the output end, fill the vacated position with 0, and increment the counter.
REQ-018 In SHIFT with ena=0, the register, counter and sout SHALL hold.
REQ-019 The last bit is consumed in the SHIFT cycle with counter = WIDTH-1 and ena=1.
REQ-020 After the last-bit edge, done SHALL be 1 for exactly one cycle.
REQ-021 After the last-bit edge, with no new load, state SHALL return to IDLE.
REQ-022 In SHIFT, load_ready SHALL be 1 only in the last-bit cycle, as a combinational function of state, counter and ena.
REQ-023 A handshake in the last-bit cycle SHALL load the new word, clear the counter, and remain in SHIFT, giving zero idle bits between frames.
REQ-024 done SHALL still pulse after a back-to-back load.
REQ-025 While load_ready=0, load_valid SHALL have no effect; upstream holds data and load_valid until accepted.
REQ-026 The counter SHALL be clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-027 A frame SHALL last exactly WIDTH ena-qualified cycles, independent of ena gaps.

Reset
REQ-028 While clr=1, outputs SHALL be: state IDLE, shift register 0, counter 0, sout=0, sout_valid=0, busy=0, done=0.
REQ-029 While clr=1, load_ready SHALL be 0.
REQ-030 On release of clr, load_ready SHALL read 1 in the first cycle.
REQ-031 A clr during SHIFT SHALL abort the frame with no done pulse; partially sent bits are discarded.
REQ-032 A clr that coincides with a handshake SHALL prevail; the word is not captured.

Structure
REQ-033 The state enumeration (IDLE, SHIFT) SHALL be defined in a shared package, shiftreg_pkg.
REQ-034 The state encoding and the default WIDTH constant SHALL reside in shiftreg_pkg.
REQ-035 Bit counting SHALL be one sub-module, bit_counter (parameter WIDTH; inputs clk, clr, clear, inc; outputs count and last).
REQ-036 Data path and FSM SHALL reside in piso_shiftreg.

Verification
REQ-037 WIDTH=4, MSB_FIRST=1, load 4'b1011, ena held 1 -> sout 1,0,1,1 in cycles 1-4 after capture; done=1 in cycle 5; busy=0 in cycle 5.
REQ-038 MSB_FIRST=0, load 4'b1011, ena=1 -> sout 1,1,0,1; done after the 4th bit.
REQ-039 Load 4'b1100, ena pattern 1,0,0,1,1,0,1 -> sout holds during ena=0; exactly 4 bits sent; done after the 7th cycle.
REQ-040 Load 4'b1010, then present 4'b0110 with load_valid in the last-bit cycle -> load_ready=1 in that cycle; sout stream 1,0,1,0,0,1,1,0 with no gap; done pulses twice.
REQ-041 load_valid asserted with 4'b1111 during bits 1-3 of a frame -> load_ready=0; word not captured until the last-bit cycle.
REQ-042 clr asserted after 2 bits of 4'b1011 -> sout=0, busy=0, no done; load_ready=1 in the first cycle after clr release.
